// File: rtl/traffic_input_conditioner_if.sv
// traffic_input_conditioner_if: field inputs, controller acknowledges and conditioned outputs
interface traffic_input_conditioner_if;
  logic ped_btn_ns_raw;
  logic ped_btn_ew_raw;
  logic sensor_ns_raw;
  logic sensor_ew_raw;
  logic emergency_raw;
  logic walk_ns;
  logic walk_ew;
  logic ped_req_ns;
  logic ped_req_ew;
  logic pedestrian;
  logic sensor_ns;
  logic sensor_ew;
  logic emergency;
  modport master (
    output ped_btn_ns_raw, ped_btn_ew_raw, sensor_ns_raw, sensor_ew_raw, emergency_raw, walk_ns, walk_ew,
    input  ped_req_ns, ped_req_ew, pedestrian, sensor_ns, sensor_ew, emergency
  );
  modport slave (
    input  ped_btn_ns_raw, ped_btn_ew_raw, sensor_ns_raw, sensor_ew_raw, emergency_raw, walk_ns, walk_ew,
    output ped_req_ns, ped_req_ew, pedestrian, sensor_ns, sensor_ew, emergency
  );
endinterface

// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner: synchronise, debounce, latch and stretch field inputs for the controller
module traffic_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMERG_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  traffic_input_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  // bit order: 0 ped_ns, 1 ped_ew, 2 sensor_ns, 3 sensor_ew, 4 emergency
  logic [4:0] raw, s1, s2;
  logic [3:0] deb, rise;
  logic [CW-1:0] cnt [4];
  logic [7:0] hcnt;
  logic [1:0] ped_req;
  logic emergency;
  assign raw = {bus.emergency_raw, bus.sensor_ew_raw, bus.sensor_ns_raw, bus.ped_btn_ew_raw, bus.ped_btn_ns_raw};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_rise
    assign rise[i] = s2[i] && !deb[i] && cnt[i] == CMAX;
  end
  // synchronise, debounce, latch requests (clear wins) and stretch emergency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      hcnt <= '0;
      ped_req <= '0;
      emergency <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int k = 0; k < 4; k++) begin
        if (s2[k] == deb[k]) cnt[k] <= '0;
        else if (cnt[k] == CMAX) begin
          deb[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
      end
      ped_req <= ~{bus.walk_ew, bus.walk_ns} & (ped_req | rise[1:0]);
      hcnt <= s2[4] ? 8'(EMERG_HOLD) : (hcnt != 8'd0 ? hcnt - 8'd1 : 8'd0);
      emergency <= s2[4] || hcnt != 8'd0;
    end
  end
  assign bus.ped_req_ns = ped_req[0];
  assign bus.ped_req_ew = ped_req[1];
  assign bus.pedestrian = ped_req[0] | ped_req[1];
  assign bus.sensor_ns = deb[2];
  assign bus.sensor_ew = deb[3];
  assign bus.emergency = emergency;
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb_traffic_input_conditioner: directed and random stimulus against a sample-history reference model
module tb_traffic_input_conditioner;
  localparam int D = 4;
  localparam int H = 8;
  logic clk, rst_n;
  traffic_input_conditioner_if bus();
  traffic_input_conditioner #(.DEBOUNCE_CYCLES(D), .EMERG_HOLD(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at time %0t", tag, got, exp, $time);
    end
  endtask
  // model: raw samples taken at every edge; a sample is void if a reset edge came at or after it
  logic [4:0] rh [0:8191];
  int t = 0, last_rst = -1;
  logic [3:0] m_deb = '0;
  logic [1:0] m_req = '0;
  logic m_em = 1'b0;
  bit chk_en = 0;
  function automatic logic s2v(input int c, input int j);
    return (j >= 0 && j > last_rst) ? rh[j][c] : 1'b0;
  endfunction
  always @(posedge clk) begin
    logic [3:0] rise;
    bit all_diff;
    t++;
    rh[t] = {bus.emergency_raw, bus.sensor_ew_raw, bus.sensor_ns_raw, bus.ped_btn_ew_raw, bus.ped_btn_ns_raw};
    rise = '0;
    if (!rst_n) begin
      last_rst = t;
      m_deb = '0;
      m_req = '0;
      m_em = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        all_diff = 1;
        for (int k = 0; k < D; k++) if (s2v(c, t - 2 - k) == m_deb[c]) all_diff = 0;
        if (all_diff) begin
          rise[c] = !m_deb[c];
          m_deb[c] = !m_deb[c];
        end
      end
      m_req[0] = bus.walk_ns ? 1'b0 : (m_req[0] | rise[0]);
      m_req[1] = bus.walk_ew ? 1'b0 : (m_req[1] | rise[1]);
      m_em = 1'b0;
      for (int k = 0; k <= H; k++) if (s2v(4, t - 2 - k)) m_em = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("ped_req_ns", 8'(bus.ped_req_ns), 8'(m_req[0]));
      check("ped_req_ew", 8'(bus.ped_req_ew), 8'(m_req[1]));
      check("pedestrian", 8'(bus.pedestrian), 8'(m_req[0] | m_req[1]));
      check("sensor_ns", 8'(bus.sensor_ns), 8'(m_deb[2]));
      check("sensor_ew", 8'(bus.sensor_ew), 8'(m_deb[3]));
      check("emergency", 8'(bus.emergency), 8'(m_em));
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_raw(input logic [4:0] v);
    {bus.emergency_raw, bus.sensor_ew_raw, bus.sensor_ns_raw, bus.ped_btn_ew_raw, bus.ped_btn_ns_raw} = v;
  endtask
  initial begin
    rst_n = 1'b0;
    set_raw('1);
    bus.walk_ns = 1'b0;
    bus.walk_ew = 1'b0;
    cyc(1);
    chk_en = 1;
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
    check("emerg_edge2", 8'(bus.emergency), 8'd0);
    cyc(1);
    check("emerg_edge3", 8'(bus.emergency), 8'd1);
    cyc(2);
    check("sensor_edge5", 8'(bus.sensor_ns), 8'd0);
    cyc(1);
    check("sensor_edge6", 8'(bus.sensor_ns), 8'd1);
    check("ped_edge6", 8'(bus.ped_req_ew), 8'd1);
    cyc(6);
    bus.walk_ns = 1'b1;
    bus.walk_ew = 1'b1;
    set_raw('0);
    cyc(1);
    bus.walk_ns = 1'b0;
    bus.walk_ew = 1'b0;
    cyc(20);
    set_raw(5'b00001);
    cyc(3);
    set_raw('0);
    cyc(12);
    check("glitch_ns", 8'(bus.ped_req_ns), 8'd0);
    set_raw(5'b00001);
    cyc(4);
    set_raw('0);
    cyc(3);
    check("held4_ns", 8'(bus.ped_req_ns), 8'd1);
    cyc(6);
    set_raw(5'b00010);
    cyc(10);
    bus.walk_ew = 1'b1;
    cyc(1);
    bus.walk_ew = 1'b0;
    cyc(5);
    check("clr_held_ew", 8'(bus.ped_req_ew), 8'd0);
    set_raw('0);
    cyc(8);
    set_raw(5'b00010);
    cyc(8);
    check("reset_ew", 8'(bus.ped_req_ew), 8'd1);
    set_raw('0);
    bus.walk_ns = 1'b1;
    bus.walk_ew = 1'b1;
    cyc(1);
    bus.walk_ns = 1'b0;
    bus.walk_ew = 1'b0;
    cyc(10);
    set_raw(5'b00001);
    cyc(5);
    bus.walk_ns = 1'b1;
    cyc(1);
    bus.walk_ns = 1'b0;
    cyc(3);
    check("simul_ns", 8'(bus.ped_req_ns), 8'd0);
    set_raw('0);
    cyc(10);
    set_raw(5'b10000);
    cyc(2);
    set_raw('0);
    cyc(5);
    set_raw(5'b10000);
    cyc(1);
    set_raw('0);
    cyc(20);
    for (int i = 0; i < 10; i++) begin
      set_raw(5'b00100);
      cyc(2);
      set_raw('0);
      cyc(2);
    end
    check("alt_sensor", 8'(bus.sensor_ns), 8'd0);
    set_raw(5'b00100);
    cyc(10);
    set_raw('0);
    cyc(10);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] v;
      v = {bus.emergency_raw, bus.sensor_ew_raw, bus.sensor_ns_raw, bus.ped_btn_ew_raw, bus.ped_btn_ns_raw};
      for (int b = 0; b < 5; b++) if ($urandom_range(5) == 0) v[b] = !v[b];
      set_raw(v);
      bus.walk_ns = ($urandom_range(9) == 0);
      bus.walk_ew = ($urandom_range(9) == 0);
      rst_n = ($urandom_range(299) != 0);
      cyc(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
